// File: rtl/truth_table_checker.sv
// Exhaustive checker for a 2-input gate: applies rows {a,b}=00..11 and compares dut_y to EXPECT.
// Latency: one row takes SETTLE_CYCLES+2 cycles; done rises 4*(SETTLE_CYCLES+2) edges after start.
// Backpressure: none; start is ignored while busy, abort cancels a run and returns to idle.
module truth_table_checker #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  EXPECT        = 4'b0001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   // Terminal value of the settle counter; SETTLE is left on the cycle the counter equals it.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [1:0] row_q;
   logic [7:0] cnt_q;
   logic       a_q;
   logic       b_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [3:0] fail_mask_q;
   logic [3:0] fail_mask_d;

   // Mask as it will stand after sampling the current row; pass is derived from this value.
   always_comb begin
      fail_mask_d        = fail_mask_q;
      fail_mask_d[row_q] = fail_mask_q[row_q] | (dut_y != EXPECT[row_q]);
   end

   // Sequencer: steps the row/settle counters and owns every registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= 2'd0;
         cnt_q       <= 8'd0;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // abort has nothing to cancel here; only start matters.
               if (start) begin
                  state_q     <= APPLY;
                  row_q       <= 2'd0;
                  fail_mask_q <= 4'd0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
               end
            end
            APPLY, SETTLE, SAMPLE: begin
               if (abort) begin
                  // Partial fail_mask is kept so the aborted run can still be inspected.
                  state_q <= IDLE;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (state_q == APPLY) begin
                  {a_q, b_q} <= row_q;
                  cnt_q      <= 8'd0;
                  state_q    <= SETTLE;
               end else if (state_q == SETTLE) begin
                  if (cnt_q == SETTLE_LAST) begin
                     state_q <= SAMPLE;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end else begin
                  fail_mask_q <= fail_mask_d;
                  if (row_q == 2'd3) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (fail_mask_d == 4'd0);
                  end else begin
                     row_q   <= row_q + 2'd1;
                     state_q <= APPLY;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker at default parameters (SETTLE_CYCLES=4, NOR expected).
// A behavioural gate model (NOR / tied-0 / OR) drives dut_y from a,b.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_truth_table_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       dut_y;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_mask;

   // 0: ideal NOR, 1: stuck at 0, 2: OR
   int unsigned mode;
   int          errors;
   int          checks;

   truth_table_checker dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .dut_y    (dut_y),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_mask(fail_mask)
   );

   assign dut_y = (mode == 0) ? ~(a | b) : (mode == 1) ? 1'b0 : (a | b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ab"},   {6'd0, a, b}, 8'd0);
      check({tag, "_busy"}, {7'd0, busy}, 8'd0);
      check({tag, "_done"}, {7'd0, done}, 8'd0);
      check({tag, "_pass"}, {7'd0, pass}, 8'd0);
   endtask

   // Called just after a falling edge. Start is sampled on edge 0; edge e counts from there.
   // restart_at > 0 re-asserts start so that it is sampled on that edge mid-run.
   task automatic do_run(input string tag, input logic [3:0] exp_mask, input logic exp_pass,
                         input int restart_at);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_busy"}, {7'd0, busy}, 8'd1);
      check({tag, "_start_mask"}, {4'd0, fail_mask}, 8'd0);
      check({tag, "_start_done"}, {7'd0, done}, 8'd0);
      for (int e = 1; e <= 24; e++) begin
         if (e == restart_at) start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (e % 6 == 1) begin
            check($sformatf("%s_row%0d_ab", tag, e / 6), {6'd0, a, b}, 8'(e / 6));
         end
         if (e == 23) begin
            check({tag, "_e23_done"}, {7'd0, done}, 8'd0);
            check({tag, "_e23_busy"}, {7'd0, busy}, 8'd1);
            check({tag, "_e23_pass"}, {7'd0, pass}, 8'd0);
         end
         if (e == 24) begin
            check({tag, "_e24_done"}, {7'd0, done}, 8'd1);
            check({tag, "_e24_busy"}, {7'd0, busy}, 8'd0);
            check({tag, "_e24_pass"}, {7'd0, pass}, {7'd0, exp_pass});
            check({tag, "_e24_mask"}, {4'd0, fail_mask}, {4'd0, exp_mask});
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mode   = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;

      // Reset state, before any clock edge
      #1;
      check_zero_outputs("reset");
      check("reset_mask", {4'd0, fail_mask}, 8'd0);
      #20;

      // Release reset with start already high: the first edge must act on it
      @(negedge clk);
      rst_n = 1'b1;
      do_run("nor", 4'b0000, 1'b1, 0);

      // abort while DONE is ignored
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done_done", {7'd0, done}, 8'd1);
      check("abort_done_pass", {7'd0, pass}, 8'd1);

      // Stuck-at-0 gate: only row 00 (expected 1) mismatches
      mode = 1;
      do_run("zero", 4'b0001, 1'b0, 0);

      // OR gate: every row is the complement of NOR
      mode = 2;
      do_run("or", 4'b1111, 1'b0, 0);

      // Second start mid-run is ignored
      mode = 0;
      do_run("restart", 4'b0000, 1'b1, 10);

      // abort during row 2 SETTLE (edges 13..17), sampled on edge 15
      mode = 1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("pre_abort_ab", {6'd0, a, b}, 8'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_zero_outputs("abort");
      check("abort_mask", {4'd0, fail_mask}, 8'h01);
      repeat (3) @(negedge clk);
      check("abort_stay_busy", {7'd0, busy}, 8'd0);

      // abort in IDLE has no effect
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_busy", {7'd0, busy}, 8'd0);
      check("abort_idle_mask", {4'd0, fail_mask}, 8'h01);

      // Full run after abort clears the mask
      mode = 0;
      do_run("after_abort", 4'b0000, 1'b1, 0);

      // Asynchronous reset during row 1 (row 0 mismatch already recorded)
      mode = 1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_mask", {4'd0, fail_mask}, 8'h01);
      check("pre_rst_ab", {6'd0, a, b}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midrst");
      check("midrst_mask", {4'd0, fail_mask}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_done", {7'd0, done}, 8'd0);
      check("post_rst_busy", {7'd0, busy}, 8'd0);

      mode = 0;
      do_run("after_rst", 4'b0000, 1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
